// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: instruction width,
// the NOP encoding, the halt opcode and the fetch-stage state encoding.
package cpu_pkg;

  localparam int INST_W = 16;
  localparam logic [3:0] OPC_HLT = 4'hF;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2,
    FS_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// Capture/hold register for an instruction that returned while decode was
// stalled. Clear has priority over load so a redirect always drops it.
module if_hold_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [INST_W-1:0] data_i,
  output logic [INST_W-1:0] data_o
);

  logic [INST_W-1:0] buf_q;

  // Hold the captured instruction until cleared or overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= NOP_INST;
    end else if (clr_i) begin
      buf_q <= NOP_INST;
    end else if (load_i) begin
      buf_q <= data_i;
    end
  end

  assign data_o = buf_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register. Owns the PC, issues one
// outstanding request at a time to a variable-latency memory, parks data
// that returns during a stall, and squashes wrong-path fetches on redirect.
// Optional feature macro: IF_HALT_EN (stop fetching on opcode 4'hF).
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_target,
  output logic              imem_req,
  output logic [15:0]       imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [INST_W-1:0] ifid_inst,
  output logic [15:0]       ifid_pc_plus2,
  output logic              ifid_valid,
  output logic              halted
);

`ifdef IF_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  fetch_state_e      state_q;
  logic [15:0]       pc_q;
  logic              squash_q;
  logic              req_q;
  logic [15:0]       addr_q;
  logic [INST_W-1:0] ifid_inst_q;
  logic [15:0]       ifid_pc2_q;
  logic              ifid_valid_q;

  logic [15:0]       pc_inc;
  logic              hb_load;
  logic              hb_clr;
  logic [INST_W-1:0] hb_data;
  logic              rdata_hlt;
  logic              hold_hlt;

  assign pc_inc    = pc_q + 16'd2;
  assign rdata_hlt = HaltEn && (imem_rdata[15:12] == OPC_HLT);
  assign hold_hlt  = HaltEn && (hb_data[15:12] == OPC_HLT);

  // Park a genuine response that arrives while decode is stalled.
  assign hb_load = (state_q == FS_REQ) && imem_valid && !branch_taken && !squash_q && stall;
  assign hb_clr  = branch_taken && (state_q != FS_IDLE);

  if_hold_buf u_hold_buf (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (hb_load),
    .clr_i  (hb_clr),
    .data_i (imem_rdata),
    .data_o (hb_data)
  );

  // Fetch FSM, PC, request registers and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      ifid_inst_q  <= NOP_INST;
      ifid_pc2_q   <= 16'h0000;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          state_q <= FS_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FS_REQ: begin
          if (branch_taken) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            pc_q         <= branch_target;
            if (imem_valid) begin
              // Outstanding request just completed: restart at target now.
              addr_q   <= branch_target;
              squash_q <= 1'b0;
            end else begin
              // Keep the in-flight request stable; drop its data later.
              squash_q <= 1'b1;
            end
          end else if (imem_valid) begin
            if (squash_q) begin
              squash_q <= 1'b0;
              addr_q   <= pc_q;
              if (!stall) begin
                ifid_valid_q <= 1'b0;
                ifid_inst_q  <= NOP_INST;
              end
            end else if (stall) begin
              state_q <= FS_HOLD;
              req_q   <= 1'b0;
            end else begin
              ifid_inst_q  <= imem_rdata;
              ifid_pc2_q   <= pc_inc;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_inc;
              addr_q       <= pc_inc;
              if (rdata_hlt) begin
                state_q <= FS_HALT;
                req_q   <= 1'b0;
              end
            end
          end else if (!stall) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
          end
        end
        FS_HOLD: begin
          if (branch_taken) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            pc_q         <= branch_target;
            addr_q       <= branch_target;
            state_q      <= FS_REQ;
            req_q        <= 1'b1;
          end else if (!stall) begin
            ifid_inst_q  <= hb_data;
            ifid_pc2_q   <= pc_inc;
            ifid_valid_q <= 1'b1;
            pc_q         <= pc_inc;
            addr_q       <= pc_inc;
            if (hold_hlt) begin
              state_q <= FS_HALT;
            end else begin
              state_q <= FS_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        FS_HALT: begin
          if (branch_taken) begin
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            pc_q         <= branch_target;
            addr_q       <= branch_target;
            state_q      <= FS_REQ;
            req_q        <= 1'b1;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_pc_plus2 = ifid_pc2_q;
  assign ifid_valid    = ifid_valid_q;

`ifdef IF_HALT_EN
  assign halted = (state_q == FS_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined core. It sits directly upstream of the decode stage, which drives the ID/EX buffer. It owns the PC and issues single-outstanding requests to a variable-latency instruction memory. It holds fetched instructions across pipeline stalls and squashes wrong-path fetches on a taken branch.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset; the first fetch address.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard stall; the IF/ID register and PC hold.
- branch_taken  in  1  redirect request from a later stage; flushes IF/ID.
- branch_target  in  16  redirect PC, valid with branch_taken.
- imem_req  out  1  fetch request; held high until accepted by imem_valid.
- imem_addr  out  16  fetch address; stable while imem_req is high.
- imem_rdata  in  16  instruction, valid with imem_valid.
- imem_valid  in  1  response strobe; sampled only while imem_req is high, may be high the same cycle.
- ifid_inst  out  16  instruction to decode; 16'h0000 (NOP) when invalid.
- ifid_pc_plus2  out  16  PC of ifid_inst + 2.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HLT (only with IF_HALT_EN).

## Operation
- States: IDLE, REQ, HOLD, HALT. Reset values:
  - state=IDLE, pc=RESET_PC, squash=0.
  - imem_req=0, imem_addr=RESET_PC.
  - ifid_inst=0, ifid_pc_plus2=0, ifid_valid=0, halted=0.
- IDLE → REQ unconditionally on the next cycle.
- REQ: imem_req=1, imem_addr=pc. On imem_valid:
  - squash=1: discard the response, clear squash, re-request at pc. pc already holds the redirect target.
  - Not stalled: load IF/ID with {imem_rdata, pc+2, valid=1}, set pc←pc+2, stay in REQ. The next request is issued in the following cycle.
  - stall=1: capture imem_rdata in the hold buffer and go to HOLD. imem_req drops.
- REQ without imem_valid: IF/ID holds if stall=1, else it loads a bubble (valid=0, inst=0).
- HOLD: imem_req=0. When stall=0, load IF/ID from the hold buffer, set pc←pc+2, go to REQ.
- branch_taken (any state except IDLE) has priority over stall and over imem_valid:
  - IF/ID ← bubble, pc ← branch_target, hold buffer discarded.
  - In REQ with a request in flight and no imem_valid this cycle: set squash=1 and keep imem_req/imem_addr unchanged until the response arrives. The request is then retried at the new pc.
  - In REQ with imem_valid this cycle: drop the data and go to REQ at the target.
  - In HOLD: go to REQ.
  - In HALT: leave HALT, go to REQ.
- PC arithmetic is mod 2^16; 16'hFFFE + 2 wraps to 16'h0000.
- Reset asserted mid-request: the state returns to reset values immediately. A late imem_valid in IDLE is ignored.

## Timing
- Zero-wait memory (imem_valid in the same cycle as imem_req): one instruction per cycle. Latency is 1 cycle from request to ifid_valid.
- N-cycle memory: one instruction every N+1 cycles.
- A redirect accepted in cycle t:
  - IF/ID is a bubble in cycle t+1.
  - The first target fetch request is issued in t+1; with squash pending, it is issued after the stale response returns.
- IF/ID never changes while stall=1, except on branch_taken.

## Configuration
- IF_HALT_EN defined: an accepted instruction with opcode [15:12]=4'hF is loaded into IF/ID and the state goes to HALT. In HALT: halted=1, imem_req=0, IF/ID holds, and the block waits for branch_taken or reset.
- IF_HALT_EN undefined: opcode 4'hF is fetched like any other instruction, HALT is unreachable, and halted is tied to 0.

## Structure
- Shared package `cpu_pkg`: the fetch state enum, OPC_HLT=4'hF, NOP_INST=16'h0000, INST_W=16.
- One sub-module, `if_hold_buf`: a 16-bit capture/hold register with load and clear inputs. The top level holds the FSM, PC and IF/ID register.

## Test plan
- Reset with RESET_PC=16'h0040 and zero-wait memory: imem_addr steps 0040, 0042, 0044 on consecutive cycles; ifid_valid=1 from the cycle after the first request.
- Stall asserted for 3 cycles while 16'h1234 returns: HOLD entered, imem_req=0. 1234 enters IF/ID exactly once after stall drops, and pc advances by 2 only once.
- branch_taken to 16'h0100 while a 2-wait request to 0046 is in flight: imem_addr stays 0046 until valid, then that data is discarded. The next request is to 0100, and IF/ID never carries the 0046 data.
- branch_taken and stall in the same cycle: IF/ID becomes a bubble and pc=target.
- PC wrap: RESET_PC=16'hFFFE gives fetches at FFFE then 0000.
- With IF_HALT_EN, fetch 16'hF000: halted=1 and imem_req=0 until branch_taken to 0010 restarts fetch. Without IF_HALT_EN, the next fetch follows immediately.
